// File: rtl/apb_multi_master.sv
// APB3 requester: takes a valid/ready command stream, decodes the slave index,
// runs SETUP/ACCESS with wait-state and timeout handling, and returns a response.
module apb_multi_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic                      cmd_write,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // SETUP  | psel asserted, penable low, one cycle
  // ACCESS | psel+penable, waiting for pready or timeout
  // RESP   | rsp_valid high until rsp_ready
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0] TO_LIM = (CNT_W+1)'(TIMEOUT);

  state_t             state, state_d;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   cmd_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_SLV-1:0] sel_vec;
  logic [DATA_W-1:0]  lane_rdata;
  logic               lane_ready, lane_err;
  logic               dec_err, timeout_hit;

  assign cmd_idx = cmd_addr[SEL_LSB +: SEL_W];
  assign dec_err = {1'b0, cmd_idx} >= (SEL_W+1)'(NUM_SLV);
  assign sel_vec = NUM_SLV'(1) << idx;
  // The cycle that would make the count reach TIMEOUT is the last ACCESS cycle.
  assign timeout_hit = (TIMEOUT != 0) && (({1'b0, cnt} + (CNT_W+1)'(1)) == TO_LIM);

  // Only the selected lane is ever looked at.
  always_comb begin
    lane_rdata = '0;
    lane_ready = 1'b0;
    lane_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        lane_rdata = prdata[i*DATA_W +: DATA_W];
        lane_ready = pready[i];
        lane_err   = pslverr[i];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    cmd_ready = 1'b0;
    psel      = '0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = presetn;
        if (cmd_valid) state_d = dec_err ? RESP : SETUP;
      end
      SETUP: begin
        psel    = sel_vec;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = sel_vec;
        penable = 1'b1;
        if (lane_ready || timeout_hit) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      idx         <= '0;
      cnt         <= '0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (dec_err) begin
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              paddr  <= cmd_addr;
              pwrite <= cmd_write;
              pwdata <= cmd_wdata;
              idx    <= cmd_idx;
              cnt    <= '0;
            end
          end
        end
        ACCESS: begin
          if (lane_ready) begin
            rsp_err     <= lane_err;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!pwrite && !lane_err) ? lane_rdata : '0;
          end else if (timeout_hit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_master.sv
// Bench for apb_multi_master: a 4-slave/TIMEOUT=16 instance and a 3-slave/TIMEOUT=4
// instance share stimulus; a transaction-level model predicts each response.
module tb_apb_multi_master;

  logic         pclk = 1'b0;
  logic         presetn = 1'b0;
  logic         use2 = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [31:0]  cmd_addr = '0;
  logic         cmd_write = 1'b0;
  logic [31:0]  cmd_wdata = '0;
  logic         rsp_ready = 1'b0;
  logic [127:0] prdata = '0;
  logic [3:0]   pready = '0;
  logic [3:0]   pslverr = '0;

  int checks = 0;
  int failures = 0;

  logic        cr1, rv1, re1, rt1, pw1, pe1;
  logic [31:0] rd1, pa1, pd1;
  logic [3:0]  ps1;
  logic        cr2, rv2, re2, rt2, pw2, pe2;
  logic [31:0] rd2, pa2, pd2;
  logic [2:0]  ps2;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout, o_pwrite, o_penable;
  logic [31:0] o_rsp_rdata, o_paddr, o_pwdata;
  logic [3:0]  o_psel;

  always #5 pclk = ~pclk;

  apb_multi_master #(.NUM_SLV(4), .TIMEOUT(16)) dut1 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid & ~use2), .cmd_ready(cr1),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1),
    .rsp_err(re1), .rsp_timeout(rt1),
    .paddr(pa1), .pwrite(pw1), .pwdata(pd1), .psel(ps1), .penable(pe1),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_multi_master #(.NUM_SLV(3), .TIMEOUT(4)) dut2 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid & use2), .cmd_ready(cr2),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2),
    .rsp_err(re2), .rsp_timeout(rt2),
    .paddr(pa2), .pwrite(pw2), .pwdata(pd2), .psel(ps2), .penable(pe2),
    .prdata(prdata[95:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0])
  );

  always_comb begin
    o_cmd_ready   = use2 ? cr2 : cr1;
    o_rsp_valid   = use2 ? rv2 : rv1;
    o_rsp_rdata   = use2 ? rd2 : rd1;
    o_rsp_err     = use2 ? re2 : re1;
    o_rsp_timeout = use2 ? rt2 : rt1;
    o_paddr       = use2 ? pa2 : pa1;
    o_pwrite      = use2 ? pw2 : pw1;
    o_pwdata      = use2 ? pd2 : pd1;
    o_psel        = use2 ? {1'b0, ps2} : ps1;
    o_penable     = use2 ? pe2 : pe1;
  end

  // One command through the selected DUT; waits = wait states the slave inserts.
  task automatic run_txn(input bit sel2, input logic [31:0] addr, input bit wr,
                         input logic [31:0] wdata, input int waits, input bit serr,
                         input logic [31:0] sdata, input int hold);
    int nslv, tmo, idx, exp_lat, exp_nsel, exp_nen, nsel, nen, lat;
    bit dec, tout, exp_err;
    logic [31:0] exp_rdata;
    logic [3:0] exp_sel;
    nslv = sel2 ? 3 : 4;
    tmo  = sel2 ? 4 : 16;
    idx  = int'(addr[13:12]);
    dec  = idx >= nslv;
    tout = !dec && waits >= tmo;
    exp_err   = dec || tout || serr;
    exp_rdata = (!dec && !tout && !wr && !serr) ? sdata : 32'h0;
    exp_sel   = 4'b0001 << idx;
    exp_lat   = dec ? 1 : (tout ? tmo + 2 : waits + 3);
    exp_nsel  = dec ? 0 : (tout ? tmo + 1 : waits + 2);
    exp_nen   = dec ? 0 : (tout ? tmo : waits + 1);
    nsel = 0; nen = 0; lat = -1;

    @(negedge pclk);
    use2 = sel2; cmd_addr = addr; cmd_write = wr; cmd_wdata = wdata; cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      failures++; $display("FAIL cmd_ready_idle got %b expected 1", o_cmd_ready);
    end
    @(posedge pclk);
    for (int c = 1; c < 100 && lat < 0; c++) begin
      @(negedge pclk);
      cmd_valid = 1'b0;
      pready  = 4'($urandom);
      pslverr = 4'($urandom);
      prdata  = {$urandom, $urandom, $urandom, $urandom};
      checks++;
      if (o_cmd_ready !== 1'b0) begin
        failures++; $display("FAIL cmd_ready_busy cycle %0d got %b expected 0", c, o_cmd_ready);
      end
      if (o_psel != 4'b0) begin
        nsel++;
        checks++;
        if (o_psel !== exp_sel || o_paddr !== addr || o_pwrite !== wr || o_pwdata !== wdata) begin
          failures++;
          $display("FAIL apb_phase cycle %0d psel %b/%b paddr %h/%h pwrite %b/%b pwdata %h/%h (got/expected)",
                   c, o_psel, exp_sel, o_paddr, addr, o_pwrite, wr, o_pwdata, wdata);
        end
        if (nsel == 1) begin
          checks++;
          if (o_penable !== 1'b0) begin
            failures++; $display("FAIL setup_penable got %b expected 0", o_penable);
          end
        end
      end
      if (o_penable === 1'b1) begin
        nen++;
        if (!dec) begin
          pready[idx] = (nen == waits + 1);
          if (nen == waits + 1) begin
            pslverr[idx] = serr;
            prdata[idx*32 +: 32] = sdata;
          end
        end
      end
      if (o_rsp_valid === 1'b1) lat = c;
    end
    pready = '0;
    checks++;
    if (lat < 0) begin
      failures++; $display("FAIL rsp_wait got no rsp_valid expected one within 100 cycles");
      return;
    end
    checks++;
    if (lat != exp_lat || nsel != exp_nsel || nen != exp_nen) begin
      failures++;
      $display("FAIL timing latency %0d/%0d psel_cycles %0d/%0d penable_cycles %0d/%0d (got/expected)",
               lat, exp_lat, nsel, exp_nsel, nen, exp_nen);
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge pclk);
      checks++;
      if (o_rsp_valid !== 1'b1 || o_rsp_err !== exp_err || o_rsp_timeout !== tout ||
          o_rsp_rdata !== exp_rdata || o_cmd_ready !== 1'b0 || o_psel !== 4'b0 || o_penable !== 1'b0) begin
        failures++;
        $display("FAIL rsp_hold %0d valid %b err %b/%b timeout %b/%b rdata %h/%h cmd_ready %b psel %b (got/expected)",
                 h, o_rsp_valid, o_rsp_err, exp_err, o_rsp_timeout, tout, o_rsp_rdata, exp_rdata,
                 o_cmd_ready, o_psel);
      end
    end
    rsp_ready = 1'b1;
    @(posedge pclk);
    #1 rsp_ready = 1'b0;
    @(negedge pclk);
    checks++;
    if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_consume rsp_valid %b expected 0 cmd_ready %b expected 1", o_rsp_valid, o_cmd_ready);
    end
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    #12;
    checks++;
    if (cr1 !== 1'b0 || rv1 !== 1'b0 || rd1 !== 32'h0 || re1 !== 1'b0 || rt1 !== 1'b0 ||
        pa1 !== 32'h0 || pw1 !== 1'b0 || pd1 !== 32'h0 || ps1 !== 4'h0 || pe1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_values cmd_ready %b rsp_valid %b rdata %h err %b to %b paddr %h pwrite %b pwdata %h psel %b penable %b expected all 0",
               cr1, rv1, rd1, re1, rt1, pa1, pw1, pd1, ps1, pe1);
    end
    @(negedge pclk);
    presetn = 1'b1;
    #1;
    checks++;
    if (cr1 !== 1'b1 || cr2 !== 1'b1) begin
      failures++; $display("FAIL reset_release cmd_ready %b %b expected 1 1", cr1, cr2);
    end
  endtask

  task automatic test_zero_wait_write();
    run_txn(1'b0, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h5555_AAAA, 0);
  endtask

  task automatic test_wait_read();
    run_txn(1'b0, 32'h0000_3010, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 0);
  endtask

  task automatic test_decode_error();
    run_txn(1'b1, 32'h0000_3000, 1'b0, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 1);
    run_txn(1'b1, 32'h0000_2000, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 32'h0000_2000, 1'b0, 32'h0, 1000, 1'b0, 32'h1111_2222, 0);
    run_txn(1'b0, 32'h0000_2040, 1'b0, 32'h0, 15, 1'b0, 32'h3333_4444, 0);
    run_txn(1'b1, 32'h0000_1000, 1'b0, 32'h0, 3, 1'b0, 32'h5555_6666, 0);
    run_txn(1'b1, 32'h0000_1000, 1'b1, 32'h7777_8888, 4, 1'b0, 32'h0, 0);
  endtask

  task automatic test_slverr_hold();
    run_txn(1'b0, 32'h0000_0020, 1'b0, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 5);
    run_txn(1'b0, 32'h0000_1024, 1'b1, 32'hA5A5_5A5A, 0, 1'b1, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge pclk);
    use2 = 1'b0; pready = '0; cmd_addr = 32'h0000_2008; cmd_write = 1'b0; cmd_valid = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    checks++;
    if (ps1 !== 4'h0 || pe1 !== 1'b0 || rv1 !== 1'b0 || cr1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid psel %b penable %b rsp_valid %b cmd_ready %b expected 0", ps1, pe1, rv1, cr1);
    end
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (rv1 !== 1'b0 || ps1 !== 4'h0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL reset_mid_no_rsp got %0d active cycles expected 0", seen);
    end
    run_txn(1'b0, 32'h0000_2008, 1'b0, 32'h0, 1, 1'b0, 32'h600D_DA7A, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit s2;
      s2 = 1'($urandom);
      run_txn(s2, $urandom, 1'($urandom), $urandom,
              s2 ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 20)),
              ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_decode_error();
    test_timeout();
    test_slverr_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
